// File: rtl/gyro_yaw_reader_if.sv
// SPI transceiver handshake plus yaw-rate result bundle for gyro_yaw_reader.
// The reader (master) drives the SPI command side and the yaw result;
// the transceiver/consumer side (slave) drives the SPI response.
interface gyro_yaw_reader_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rsp;
    logic [15:0] yaw_rt;
    logic        vld;
    logic        init_done;

    modport master (
        output wrt, cmd, yaw_rt, vld, init_done,
        input  done, rsp
    );

    modport slave (
        input  wrt, cmd, yaw_rt, vld, init_done,
        output done, rsp
    );
endinterface

// File: rtl/gyro_yaw_reader.sv
// Gyro yaw-rate reader: waits out gyro power-up, writes three configuration
// registers over a 16-bit SPI transceiver, then on every data-ready interrupt
// reads the yaw-rate low/high bytes and presents the signed 16-bit result
// with a one-clock vld pulse.
module gyro_yaw_reader #(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               INT,
    gyro_yaw_reader_if.master  bus
);

    localparam logic [15:0] CMD_INT_EN  = 16'h0D02;
    localparam logic [15:0] CMD_RATE    = 16'h1160;
    localparam logic [15:0] CMD_ROUND   = 16'h1440;
    localparam logic [15:0] CMD_RD_LOW  = 16'hA600;
    localparam logic [15:0] CMD_RD_HIGH = 16'hA700;

    typedef enum logic [2:0] {
        PWRUP,
        CFG1,
        CFG2,
        CFG3,
        WAIT_INT,
        RD_L,
        RD_H,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] timer;
    logic        timer_full;
    logic        int_ff1;
    logic        int_ff2;
    logic [7:0]  yaw_l;

    logic        wrt_nxt;
    logic [15:0] cmd_nxt;
    logic [7:0]  yaw_l_nxt;
    logic [15:0] yaw_rt_nxt;
    logic        vld_nxt;
    logic        init_done_nxt;

    // Short wait in simulation, full 2^16-clock wait on silicon.
    assign timer_full = FAST_SIM ? (&timer[8:0]) : (&timer);

    // Two-flop synchronizer for the asynchronous data-ready interrupt.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ff1 <= 1'b0;
            int_ff2 <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
        end
    end

    // Power-up timer runs only while waiting for the gyro to come alive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= 16'h0000;
        end else if (state == PWRUP) begin
            timer <= timer + 16'd1;
        end
    end

    // State register and registered SPI/yaw outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= PWRUP;
            bus.wrt       <= 1'b0;
            bus.cmd       <= 16'h0000;
            yaw_l         <= 8'h00;
            bus.yaw_rt    <= 16'h0000;
            bus.vld       <= 1'b0;
            bus.init_done <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.wrt       <= wrt_nxt;
            bus.cmd       <= cmd_nxt;
            yaw_l         <= yaw_l_nxt;
            bus.yaw_rt    <= yaw_rt_nxt;
            bus.vld       <= vld_nxt;
            bus.init_done <= init_done_nxt;
        end
    end

    // Next-state and next-output decode; each SPI transaction is launched
    // only from PWRUP/WAIT_INT or on the done of the previous one.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
        state_nxt     = state;
        wrt_nxt       = 1'b0;
        cmd_nxt       = bus.cmd;
        yaw_l_nxt     = yaw_l;
        yaw_rt_nxt    = bus.yaw_rt;
        vld_nxt       = 1'b0;
        init_done_nxt = bus.init_done;

        case (state)
            PWRUP: begin
                if (timer_full) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_INT_EN;
                    state_nxt = CFG1;
                end
            end
            CFG1: begin
                if (bus.done) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_RATE;
                    state_nxt = CFG2;
                end
            end
            CFG2: begin
                if (bus.done) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_ROUND;
                    state_nxt = CFG3;
                end
            end
            CFG3: begin
                if (bus.done) begin
                    init_done_nxt = 1'b1;
                    state_nxt     = WAIT_INT;
                end
            end
            WAIT_INT: begin
                if (int_ff2) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_RD_LOW;
                    state_nxt = RD_L;
                end
            end
            RD_L: begin
                if (bus.done) begin
                    yaw_l_nxt = bus.rsp[7:0];
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_RD_HIGH;
                    state_nxt = RD_H;
                end
            end
            RD_H: begin
                if (bus.done) begin
                    yaw_rt_nxt = {bus.rsp[7:0], yaw_l};
                    vld_nxt    = 1'b1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                // Gives the synchronizer time to see INT fall after the high-byte read.
                state_nxt = WAIT_INT;
            end
            default: begin
                state_nxt = PWRUP;
            end
        endcase
    end

endmodule

// File: tb/tb_gyro_yaw_reader.sv
// Self-checking bench for gyro_yaw_reader: a gyro/transceiver model answers
// each SPI write, expected commands and yaw results are queued by the
// stimulus and checked by an independent monitor.
module tb_gyro_yaw_reader;

    logic clk = 1'b0;
    logic rst_n;
    logic INT;

    gyro_yaw_reader_if bus ();

    gyro_yaw_reader #(.FAST_SIM(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .INT   (INT),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_cmd_q[$];
    logic [15:0] exp_yaw_q[$];
    logic [15:0] last_yaw = 16'h0000;
    logic [15:0] mon_exp;
    logic        prev_wrt = 1'b0;
    logic        prev_vld = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: yaw rate is the signed high byte scaled by 256 plus the unsigned low byte.
    function automatic logic [15:0] yaw_model(input logic [15:0] lo, input logic [15:0] hi);
        int hi_s;
        int lo_u;
        int v;
        logic [7:0] hb;
        hb   = hi[7:0];
        hi_s = (hb >= 8'd128) ? int'(hb) - 256 : int'(hb);
        lo_u = int'(lo[7:0]);
        v    = hi_s * 256 + lo_u;
        return v[15:0];
    endfunction

    // Monitor: compares every wrt and vld against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wrt = 1'b0;
            prev_vld = 1'b0;
            last_yaw = 16'h0000;
        end else begin
            if (bus.wrt) begin
                check("wrt_single_pulse", {31'd0, prev_wrt}, 32'd0);
                if (exp_cmd_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_wrt: cmd 0x%h issued, none expected", bus.cmd);
                end else begin
                    mon_exp = exp_cmd_q.pop_front();
                    check("cmd", {16'd0, bus.cmd}, {16'd0, mon_exp});
                end
            end
            if (bus.vld) begin
                check("vld_single_pulse", {31'd0, prev_vld}, 32'd0);
                if (exp_yaw_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_vld: yaw_rt 0x%h, no read expected", bus.yaw_rt);
                end else begin
                    mon_exp = exp_yaw_q.pop_front();
                    check("yaw_rt", {16'd0, bus.yaw_rt}, {16'd0, mon_exp});
                    last_yaw = mon_exp;
                end
            end else begin
                check("yaw_hold", {16'd0, bus.yaw_rt}, {16'd0, last_yaw});
            end
            prev_wrt = bus.wrt;
            prev_vld = bus.vld;
        end
    end

    // Waits (bounded) for the next wrt pulse; returns the clocks waited.
    task automatic wait_wrt(input string name, output bit ok, output int cycles);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            cycles = i + 1;
            if (bus.wrt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no wrt within 2000 clocks, got none, expected one", name);
        end
    endtask

    // Transceiver model: done pulse with response after 'delay' clocks.
    task automatic answer(input int delay, input logic [15:0] r, input bit drop_int);
        repeat (delay) @(negedge clk);
        bus.rsp  = r;
        bus.done = 1'b1;
        if (drop_int) INT = 1'b0;
        @(posedge clk);
        #1;
        bus.done = 1'b0;
        bus.rsp  = 16'($urandom);
    endtask

    // Releases reset and walks the gyro through power-up and configuration.
    task automatic powerup_and_config();
        bit ok;
        int cyc;
        exp_cmd_q.push_back(16'h0D02);
        @(negedge clk);
        rst_n = 1'b1;
        wait_wrt("pwrup_wrt", ok, cyc);
        check("pwrup_delay_511_to_513", {31'd0, (cyc >= 511 && cyc <= 513)}, 32'd1);
        check("init_done_during_cfg", {31'd0, bus.init_done}, 32'd0);
        // Done held low: any further wrt here is flagged by the monitor.
        repeat (40) @(negedge clk);
        exp_cmd_q.push_back(16'h1160);
        answer(10, 16'($urandom), 1'b0);
        wait_wrt("cfg1_wrt", ok, cyc);
        exp_cmd_q.push_back(16'h1440);
        // Interrupt during configuration must not start a read.
        repeat (2) @(negedge clk);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        answer(5, 16'($urandom), 1'b0);
        wait_wrt("cfg2_wrt", ok, cyc);
        check("init_done_before_cfg3_done", {31'd0, bus.init_done}, 32'd0);
        answer(10, 16'($urandom), 1'b0);
        check("init_done_after_cfg3_done", {31'd0, bus.init_done}, 32'd1);
        // Spurious done in WAIT_INT: no wrt, no state change.
        answer(3, 16'($urandom), 1'b0);
        repeat (20) @(negedge clk);
        check("init_done_after_spurious_done", {31'd0, bus.init_done}, 32'd1);
    endtask

    // One yaw read; INT left high when !drop so the next read starts by itself.
    task automatic read_txn(input logic [15:0] lo, input logic [15:0] hi, input bit drop);
        bit ok;
        int cyc;
        if (!INT) begin
            exp_cmd_q.push_back(16'hA600);
            INT = 1'b1;
        end
        wait_wrt("rd_l_wrt", ok, cyc);
        exp_cmd_q.push_back(16'hA700);
        answer($urandom_range(1, 12), lo, 1'b0);
        wait_wrt("rd_h_wrt", ok, cyc);
        check("yaw_no_partial_update", {16'd0, bus.yaw_rt}, {16'd0, last_yaw});
        exp_yaw_q.push_back(yaw_model(lo, hi));
        if (!drop) exp_cmd_q.push_back(16'hA600);
        answer($urandom_range(1, 12), hi, drop);
        check("vld_latency", {31'd0, bus.vld}, 32'd1);
        if (drop) repeat ($urandom_range(3, 15)) @(negedge clk);
    endtask

    initial begin
        bit ok;
        int cyc;
        logic [15:0] lo;
        logic [15:0] hi;

        INT      = 1'b0;
        bus.done = 1'b0;
        bus.rsp  = 16'h0000;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wrt",       {31'd0, bus.wrt},       32'd0);
        check("rst_cmd",       {16'd0, bus.cmd},       32'd0);
        check("rst_yaw_rt",    {16'd0, bus.yaw_rt},    32'd0);
        check("rst_vld",       {31'd0, bus.vld},       32'd0);
        check("rst_init_done", {31'd0, bus.init_done}, 32'd0);

        powerup_and_config();

        read_txn(16'h0034, 16'h0012, 1'b1);
        check("yaw_0x1234", {16'd0, bus.yaw_rt}, 32'h0000_1234);
        read_txn(16'h00F0, 16'hFF80, 1'b1);
        check("yaw_negative", 32'($signed(bus.yaw_rt)), 32'(-32528));

        for (int i = 0; i < 12; i++) begin
            lo = 16'($urandom);
            hi = 16'($urandom);
            read_txn(lo, hi, (i == 11) || ($urandom_range(0, 3) != 0));
        end

        // Reset between the low-byte and high-byte transactions.
        exp_cmd_q.push_back(16'hA600);
        INT = 1'b1;
        wait_wrt("pre_rst_rd_l_wrt", ok, cyc);
        exp_cmd_q.push_back(16'hA700);
        answer(4, 16'h0077, 1'b0);
        wait_wrt("pre_rst_rd_h_wrt", ok, cyc);
        #2;
        rst_n = 1'b0;
        INT   = 1'b0;
        #1;
        check("midrst_wrt",       {31'd0, bus.wrt},       32'd0);
        check("midrst_cmd",       {16'd0, bus.cmd},       32'd0);
        check("midrst_yaw_rt",    {16'd0, bus.yaw_rt},    32'd0);
        check("midrst_vld",       {31'd0, bus.vld},       32'd0);
        check("midrst_init_done", {31'd0, bus.init_done}, 32'd0);
        repeat (2) @(posedge clk);

        powerup_and_config();
        read_txn(16'($urandom), 16'($urandom), 1'b1);

        repeat (20) @(negedge clk);
        check("cmd_queue_drained", exp_cmd_q.size(), 32'd0);
        check("yaw_queue_drained", exp_yaw_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gyro_yaw_reader.md
Name: gyro_yaw_reader

Overview:
- Producer side of the yaw_rt/vld interface consumed by the heading integrator.
- Powers up and configures the gyro over an external 16-bit SPI transceiver: wrt/cmd out, done/rsp in.
- On each gyro data-ready interrupt, reads the yaw-rate low and high bytes and presents the signed 16-bit rate with a one-clock vld pulse.

Parameters:
FAST_SIM, 1, 1 = power-up wait of 2^9 clocks (simulation); 0 = 2^16 clocks.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
INT  input  1  gyro data-ready interrupt, asynchronous, active high
done  input  1  SPI transceiver: transaction complete, one-clock pulse
rsp  input  16  SPI transceiver: response word, valid while done is high
wrt  output  1  SPI transceiver: start transaction, one-clock pulse
cmd  output  16  SPI transceiver: command word
yaw_rt  output  16  signed yaw rate {high byte, low byte}
vld  output  1  one-clock pulse, yaw_rt newly updated
init_done  output  1  high once gyro configuration is complete

Behaviour:
- Clock and reset: one clock (clk). Asynchronous active-low reset (rst_n).
- Reset values: wrt=0, cmd=16'h0000, yaw_rt=16'h0000, vld=0, init_done=0. Power-up timer=0, state=PWRUP, INT synchronizer flops=0, yawL=8'h00.
- INT synchronization: INT passes through two flops (INT_ff1, INT_ff2). Only INT_ff2 is used.
- Power-up timer: 16-bit counter, increments every clock in PWRUP only. "Full" is timer[8:0]==all ones when FAST_SIM=1, else timer==16'hFFFF.
- wrt and cmd are registered:
  - wrt is high exactly one clock per transaction.
  - cmd is loaded on the same edge that wrt rises and holds until the next load.
- States and transitions:
  - PWRUP: when full, issue cmd 16'h0D02 (data-ready interrupt enable) -> CFG1.
  - CFG1: on done, issue 16'h1160 (rate/range setup) -> CFG2.
  - CFG2: on done, issue 16'h1440 (rounding enable) -> CFG3.
  - CFG3: on done -> WAIT_INT; init_done set to 1 on that edge and held until reset.
  - WAIT_INT: if INT_ff2, issue 16'hA600 (read yaw low) -> RD_L.
  - RD_L: on done, capture yawL<=rsp[7:0] and issue 16'hA700 (read yaw high) -> RD_H.
  - RD_H: on done, yaw_rt<={rsp[7:0],yawL} and vld<=1 on the same edge -> HOLD.
  - HOLD: one clock, lets the INT synchronizer observe INT dropping -> WAIT_INT.
- Latency: vld rises the clock after the RD_H done pulse; yaw_rt is stable from that edge until the next vld.
- rsp[15:8] is ignored.
- done outside CFG1/CFG2/CFG3/RD_L/RD_H is ignored, with no state change.
- INT is ignored in every state except WAIT_INT. An INT that is still high when WAIT_INT is re-entered starts a new read; the gyro clears INT when the high byte is read.
- yaw_rt holds its last value between reads. No partial update: the yawL capture alone never changes yaw_rt.
- Reset asserted at any point (mid-config or mid-read) returns to PWRUP, restarts the timer, clears init_done, and redoes the full configuration.
- Never more than one outstanding SPI transaction: wrt only issues from PWRUP/WAIT_INT or on a done edge.

Test Plan:
1. Reset release, FAST_SIM=1, done held low -> first wrt exactly 512 clocks (+/-1 for the registered output) after reset release, cmd=0x0D02; no second wrt while done stays low.
2. Answer each wrt with done 10 clocks later -> cmds in order 0x0D02, 0x1160, 0x1440, each wrt a single-clock pulse; init_done rises on the third done; no further wrt while INT=0.
3. After init, INT=1; model returns rsp=0x0034 then 0x0012 and drops INT on the second read -> cmds 0xA600 then 0xA700; vld single pulse one clock after the second done with yaw_rt=0x1234; yaw_rt unchanged after the first done.
4. Negative rate: rsp low=0x00F0, high=0xFF80 -> yaw_rt=0x80F0 (signed -32528); rsp high byte bits ignored.
5. INT pulsed during CFG2, spurious done in WAIT_INT -> no read issued until init_done; no state change or wrt on the spurious done.
6. rst_n low for 2 clocks between the 0xA600 and 0xA700 transactions -> all outputs at reset values immediately; after release, full power-up wait then 0x0D02 again; no vld until a complete new read.
